// File: rtl/debug_pkg.sv
// Shared debug-port definitions: command codes, FSM state encoding, register index width.
package debug_pkg;
    localparam int REG_SEL_W = 4;

    typedef enum logic [1:0] {
        DBG_NONE = 2'b00,
        DBG_STOP = 2'b01,
        DBG_STEP = 2'b10,
        DBG_RUN  = 2'b11
    } dbg_mode_t;

    typedef enum logic [1:0] {
        RUNNING  = 2'b00,
        STOPPING = 2'b01,
        STOPPED  = 2'b10,
        STEPPING = 2'b11
    } dbg_state_t;
endpackage

// File: rtl/debug_wbuf.sv
// One-entry deferred debug write buffer; a push to a full buffer that is not popping
// in the same cycle replaces the entry and pulses overwrite.
module debug_wbuf
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_SEL_W-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  pop,
    output logic                  full,
    output logic [REG_SEL_W-1:0]  out_sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  overwrite
);
    assign overwrite = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            out_sel  <= '0;
            out_data <= '0;
        end else if (push) begin
            full     <= 1'b1;
            out_sel  <= sel;
            out_data <= data;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end
endmodule

// File: rtl/cpu_debug_port.sv
// Per-core debug responder: run/stop/step FSM gating issue, 1-cycle registered reads,
// and register writes that are deferred until the core is stopped.
module cpu_debug_port
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter bit START_RUNNING = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cpu_mode,
    input  logic [REG_SEL_W-1:0]  reg_sel,
    input  logic                  reg_we,
    input  logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_stopped,
    output logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  core_run,
    input  logic                  core_idle,
    input  logic                  core_retire,
    output logic [REG_SEL_W-1:0]  core_reg_sel,
    output logic                  core_reg_we,
    output logic [DATA_WIDTH-1:0] core_reg_wdata,
    input  logic [DATA_WIDTH-1:0] core_reg_rdata,
    output logic                  dbg_overrun
);
    localparam dbg_state_t RESET_STATE = START_RUNNING ? RUNNING : STOPPED;

    dbg_state_t            state;
    logic                  buf_full;
    logic [REG_SEL_W-1:0]  buf_sel;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_overwrite;
    logic                  commit;
    logic                  direct_wr;
    logic                  push;
    logic                  is_run;

    assign is_run = (cpu_mode == DBG_RUN);

    // A buffered write always takes precedence; a new strobe in that cycle queues behind it.
    assign commit    = (state == STOPPED) && buf_full;
    assign direct_wr = reg_we && (state == STOPPED) && !buf_full;
    assign push      = reg_we && !direct_wr;

    debug_wbuf #(.DATA_WIDTH(DATA_WIDTH)) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .sel       (reg_sel),
        .data      (reg_wdata),
        .pop       (commit),
        .full      (buf_full),
        .out_sel   (buf_sel),
        .out_data  (buf_data),
        .overwrite (buf_overwrite)
    );

    assign core_reg_we    = commit || direct_wr;
    assign core_reg_sel   = commit ? buf_sel : reg_sel;
    assign core_reg_wdata = commit ? buf_data : (direct_wr ? reg_wdata : '0);

    assign core_run    = (state == RUNNING) || (state == STEPPING);
    assign reg_stopped = (state == STOPPED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            case (state)
                RUNNING:  if (cpu_mode == DBG_STOP) state <= STOPPING;
                STOPPING: if (is_run) state <= RUNNING;
                          else if (core_idle) state <= STOPPED;
                STOPPED:  if (is_run) state <= RUNNING;
                          else if (cpu_mode == DBG_STEP) state <= STEPPING;
                STEPPING: if (cpu_mode == DBG_STOP) state <= STOPPING;
                          else if (is_run) state <= RUNNING;
                          else if (core_retire) state <= STOPPING;
                default:  state <= RESET_STATE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata   <= '0;
            dbg_overrun <= 1'b0;
        end else begin
            reg_rdata <= core_reg_rdata;
            if (buf_overwrite)
                dbg_overrun <= 1'b1;
            else if (is_run)
                dbg_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_debug_port.sv
// Directed bench for cpu_debug_port: FSM sequencing, deferred writes, overrun, reads, reset.
module tb_cpu_debug_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cpu_mode;
    logic [3:0]  reg_sel;
    logic        reg_we;
    logic [15:0] reg_wdata;
    logic        reg_stopped;
    logic [15:0] reg_rdata;
    logic        core_run;
    logic        core_idle;
    logic        core_retire;
    logic [3:0]  core_reg_sel;
    logic        core_reg_we;
    logic [15:0] core_reg_wdata;
    logic [15:0] core_reg_rdata;
    logic        dbg_overrun;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cpu_debug_port #(.DATA_WIDTH(16), .START_RUNNING(1'b0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_mode       (cpu_mode),
        .reg_sel        (reg_sel),
        .reg_we         (reg_we),
        .reg_wdata      (reg_wdata),
        .reg_stopped    (reg_stopped),
        .reg_rdata      (reg_rdata),
        .core_run       (core_run),
        .core_idle      (core_idle),
        .core_retire    (core_retire),
        .core_reg_sel   (core_reg_sel),
        .core_reg_we    (core_reg_we),
        .core_reg_wdata (core_reg_wdata),
        .core_reg_rdata (core_reg_rdata),
        .dbg_overrun    (dbg_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cpu_mode = 2'b00; reg_sel = 4'd0; reg_we = 1'b0; reg_wdata = 16'h0;
        core_idle = 1'b0; core_retire = 1'b0; core_reg_rdata = 16'h0;
        tick(); tick();
        rst_n = 1'b1;
        #1;

        // 1: reset state
        check("rst_stopped", reg_stopped, 1);
        check("rst_core_run", core_run, 0);
        check("rst_rdata", reg_rdata, 16'h0);
        check("rst_overrun", dbg_overrun, 0);
        check("rst_reg_we", core_reg_we, 0);

        // 2: run, then stop with core busy for 3 cycles
        tick();
        cpu_mode = 2'b11; tick(); cpu_mode = 2'b00;
        check("run_core_run", core_run, 1);
        check("run_not_stopped", reg_stopped, 0);
        cpu_mode = 2'b01; tick(); cpu_mode = 2'b00;
        check("stopping_core_run", core_run, 0);
        check("stopping_not_stopped", reg_stopped, 0);
        tick(); tick();
        check("busy_not_stopped", reg_stopped, 0);
        core_idle = 1'b1; #1;
        check("idle_same_cycle", reg_stopped, 0);
        tick();
        check("idle_stopped", reg_stopped, 1);

        // 3: single step; retire on 2nd run cycle
        cpu_mode = 2'b10; tick(); cpu_mode = 2'b00;
        check("step_run_c1", core_run, 1);
        tick();
        core_retire = 1'b1;
        check("step_run_c2", core_run, 1);
        tick(); core_retire = 1'b0;
        check("step_done_run", core_run, 0);
        check("step_stopping", reg_stopped, 0);
        tick();
        check("step_stopped", reg_stopped, 1);

        // 4: write while running is deferred until stopped
        cpu_mode = 2'b11; tick(); cpu_mode = 2'b00;
        reg_we = 1'b1; reg_sel = 4'd5; reg_wdata = 16'hBEEF; #1;
        check("defer_we_low", core_reg_we, 0);
        check("defer_wdata_zero", core_reg_wdata, 16'h0);
        tick(); reg_we = 1'b0; reg_sel = 4'd9; reg_wdata = 16'h0;
        cpu_mode = 2'b01; tick(); cpu_mode = 2'b00;
        check("defer_stopping_we", core_reg_we, 0);
        tick();
        check("commit_stopped", reg_stopped, 1);
        check("commit_we", core_reg_we, 1);
        check("commit_sel", core_reg_sel, 4'd5);
        check("commit_data", core_reg_wdata, 16'hBEEF);
        tick();
        check("post_commit_we", core_reg_we, 0);
        check("post_commit_sel", core_reg_sel, 4'd9);
        check("post_commit_data", core_reg_wdata, 16'h0);

        // 5: two deferred writes -> overrun, last one wins, run clears overrun
        cpu_mode = 2'b11; tick(); cpu_mode = 2'b00;
        reg_we = 1'b1; reg_sel = 4'd3; reg_wdata = 16'h0001; tick();
        check("ovr_after_first", dbg_overrun, 0);
        reg_wdata = 16'h0002; tick();
        reg_we = 1'b0; reg_sel = 4'd0; reg_wdata = 16'h0;
        check("ovr_set", dbg_overrun, 1);
        cpu_mode = 2'b01; tick(); cpu_mode = 2'b00;
        tick();
        check("ovr_commit_we", core_reg_we, 1);
        check("ovr_commit_sel", core_reg_sel, 4'd3);
        check("ovr_commit_data", core_reg_wdata, 16'h0002);
        tick();
        check("ovr_single_commit", core_reg_we, 0);
        check("ovr_sticky", dbg_overrun, 1);
        cpu_mode = 2'b11; tick(); cpu_mode = 2'b00;
        check("ovr_cleared", dbg_overrun, 0);
        check("ovr_run", core_run, 1);
        cpu_mode = 2'b01; tick(); cpu_mode = 2'b00;
        tick();
        check("back_stopped", reg_stopped, 1);

        // direct write while stopped with empty buffer
        reg_we = 1'b1; reg_sel = 4'd2; reg_wdata = 16'h0055; #1;
        check("direct_we", core_reg_we, 1);
        check("direct_sel", core_reg_sel, 4'd2);
        check("direct_data", core_reg_wdata, 16'h0055);
        tick(); reg_we = 1'b0; reg_wdata = 16'h0;

        // 6: registered read
        reg_sel = 4'd7; core_reg_rdata = 16'h1234; #1;
        check("read_sel", core_reg_sel, 4'd7);
        tick();
        check("read_data", reg_rdata, 16'h1234);

        // reset during step discards a pending write
        cpu_mode = 2'b10; tick(); cpu_mode = 2'b00;
        check("rst_step_running", core_run, 1);
        reg_we = 1'b1; reg_sel = 4'd4; reg_wdata = 16'hAAAA; tick();
        reg_we = 1'b0; reg_sel = 4'd7; reg_wdata = 16'h0;
        #2 rst_n = 1'b0; #1;
        check("async_rst_stopped", reg_stopped, 1);
        check("async_rst_run", core_run, 0);
        check("async_rst_rdata", reg_rdata, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_no_commit_we", core_reg_we, 0);
        check("rst_no_commit_data", core_reg_wdata, 16'h0);
        check("rst_stays_stopped", reg_stopped, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
